cdc_req_arbiter: RTL and testbench



---
 rtl/cdc_req_arbiter.sv | 131 +++++++++++++
 tb/tb_cdc_req_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_req_arbiter.sv
// Round-robin receive-side arbiter for 4-phase req/ack CDC handshakes.
// Optional macro HS_TIMEOUT_EN aborts an ack phase whose request never drops.
module cdc_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          CLK,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_sync,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [$clog2(NUM_REQ)-1:0]    out_src,
  input  logic                          out_ready,
  output logic                          busy,
  output logic                          err
);

  localparam int SRC_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("cdc_req_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, XFER, ACK} state_t;

  state_t                  state;
  logic [SRC_W-1:0]        rr_ptr;
  logic                    pick_vld;
  logic [SRC_W-1:0]        pick_idx;
  logic [SRC_W-1:0]        cand;
  logic [DATA_WIDTH-1:0]   pick_data;
  logic [SRC_W-1:0]        next_ptr;
  logic [NUM_REQ-1:0]      ack_grant;
  logic [DATA_WIDTH-1:0]   slice [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign slice[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Descending scan so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = SRC_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_sync[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  assign pick_data = slice[pick_idx];
  assign next_ptr  = (int'(out_src) == NUM_REQ - 1) ? '0 : out_src + 1'b1;
  assign ack_grant = {{(NUM_REQ-1){1'b0}}, 1'b1} << out_src;
  assign busy      = (state != IDLE);

`ifdef HS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      ack       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
`ifdef HS_TIMEOUT_EN
      err       <= 1'b0;
      to_cnt    <= '0;
`endif
    end else begin
`ifdef HS_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (pick_vld) begin
            out_data  <= pick_data;
            out_src   <= pick_idx;
            out_valid <= 1'b1;
            state     <= XFER;
          end
        end
        // Captured word is delivered even if its request has already dropped.
        XFER: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            ack       <= ack_grant;
            state     <= ACK;
`ifdef HS_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        ACK: begin
          if (!req_sync[out_src]) begin
            ack    <= '0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
`ifdef HS_TIMEOUT_EN
          else if (to_hit) begin
            ack    <= '0;
            rr_ptr <= next_ptr;
            err    <= 1'b1;
            state  <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// Bench for cdc_req_arbiter: vector table, directed corner sequences, and a
// randomized run against a transaction-level reference model.
module tb_cdc_req_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 8;

  logic            CLK = 1'b0;
  logic            rst;
  logic [N-1:0]    req_sync;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ack;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [1:0]      out_src;
  logic            out_ready;
  logic            busy;
  logic            err;

  int errors = 0;
  int checks = 0;

  cdc_req_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .rst(rst), .req_sync(req_sync), .data_in(data_in), .ack(ack),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [N-1:0]  req;
    logic          rdy;
    logic          ev;
    logic [1:0]    es;
    logic [DW-1:0] ed;
    logic [N-1:0]  ea;
    logic          eb;
  } vec_t;

  vec_t vecs[12];

  // reference model and requester agents
  int            m_ptr, m_src, m_ack, words, idx, ack_cycles, err_pulses, nrr;
  bit            m_word, found, to_done, held;
  logic [DW-1:0] m_data;
  logic [N-1:0]  pr, exp_ack, ag_req;
  logic          prdy, prev_valid;
  int            ag_st[N], ag_wait[N], ackcnt[N], rr_seen[5];
  logic [DW-1:0] ag_data[N];
  int            exp_rr[5] = '{0, 1, 2, 3, 0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_sync = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_sync = '0;
    data_in = '0;
    out_ready = 1'b0;

    // reset with random request activity
    for (int i = 0; i < 3; i++) begin
      req_sync  = 4'($urandom);
      out_ready = 1'($urandom);
      tick();
      chk("rst_ack", ack, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_src", out_src, 0);
      chk("rst_err", err, 0);
    end
    rst = 1'b0;
    req_sync = '0;
    tick();
    chk("rel_ack", ack, 0);
    chk("rel_valid", out_valid, 0);
    chk("rel_busy", busy, 0);
    chk("rel_src", out_src, 0);

    // vector table: single transfer, pointer advance, backpressure, wrap
    vecs[0]  = '{4'b0100, 1'b1, 1'b1, 2'd2, 8'hA5, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0100, 1'b1, 1'b0, 2'd2, 8'hA5, 4'b0100, 1'b1};
    vecs[2]  = '{4'b0000, 1'b1, 1'b0, 2'd2, 8'hA5, 4'b0000, 1'b0};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 2'd2, 8'hA5, 4'b0000, 1'b0};
    vecs[4]  = '{4'b1001, 1'b0, 1'b1, 2'd3, 8'h44, 4'b0000, 1'b1};
    vecs[5]  = '{4'b1001, 1'b0, 1'b1, 2'd3, 8'h44, 4'b0000, 1'b1};
    vecs[6]  = '{4'b1001, 1'b1, 1'b0, 2'd3, 8'h44, 4'b1000, 1'b1};
    vecs[7]  = '{4'b1001, 1'b1, 1'b0, 2'd3, 8'h44, 4'b1000, 1'b1};
    vecs[8]  = '{4'b0001, 1'b1, 1'b0, 2'd3, 8'h44, 4'b0000, 1'b0};
    vecs[9]  = '{4'b0001, 1'b1, 1'b1, 2'd0, 8'h11, 4'b0000, 1'b1};
    vecs[10] = '{4'b0001, 1'b1, 1'b0, 2'd0, 8'h11, 4'b0001, 1'b1};
    vecs[11] = '{4'b0000, 1'b1, 1'b0, 2'd0, 8'h11, 4'b0000, 1'b0};
    data_in = 32'h44A5_2211;
    for (int i = 0; i < 12; i++) begin
      req_sync  = vecs[i].req;
      out_ready = vecs[i].rdy;
      tick();
      chk($sformatf("vec%0d_valid", i), out_valid, vecs[i].ev);
      chk($sformatf("vec%0d_src", i), out_src, vecs[i].es);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].ed);
      chk($sformatf("vec%0d_ack", i), ack, vecs[i].ea);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
    end

    // round robin with all requesters busy; each drops req 2 cycles into ack
    do_reset();
    data_in = 32'h1312_1110;
    req_sync = 4'b1111;
    out_ready = 1'b1;
    nrr = 0;
    prev_valid = 1'b0;
    for (int i = 0; i < N; i++) ackcnt[i] = 0;
    for (int t = 0; t < 80 && nrr < 5; t++) begin
      tick();
      chk("rr_ack_onehot", ($countones(ack) <= 1), 1);
      chk("rr_valid_vs_ack", (out_valid && (ack != 0)), 0);
      if (out_valid && !prev_valid) begin
        rr_seen[nrr] = int'(out_src);
        nrr++;
      end
      prev_valid = out_valid;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          ackcnt[i]++;
          if (ackcnt[i] >= 2) req_sync[i] = 1'b0;
        end else begin
          ackcnt[i] = 0;
          req_sync[i] = 1'b1;
        end
      end
    end
    chk("rr_grant_count", nrr, 5);
    for (int i = 0; i < 5; i++)
      if (i < nrr) chk($sformatf("rr_src%0d", i), rr_seen[i], exp_rr[i]);

    // backpressure for 10 cycles, then single accept
    do_reset();
    data_in = 32'h0000_5C00;
    req_sync = 4'b0010;
    tick();
    chk("bp_valid", out_valid, 1);
    chk("bp_src", out_src, 1);
    held = 1'b1;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (out_valid !== 1'b1 || out_src !== 2'd1 || out_data !== 8'h5C || ack !== 4'b0000)
        held = 1'b0;
    end
    chk("bp_stable", held, 1);
    out_ready = 1'b1;
    tick();
    chk("bp_accept_valid", out_valid, 0);
    chk("bp_accept_ack", ack, 4'b0010);
    tick();
    chk("bp_single_valid", out_valid, 0);
    chk("bp_ack_held", ack, 4'b0010);

    // reset in the middle of the ack phase
    rst = 1'b1;
    tick();
    chk("mid_rst_ack", ack, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    chk("mid_rst_regrant_valid", out_valid, 1);
    chk("mid_rst_regrant_src", out_src, 1);
    tick();
    req_sync = '0;
    tick();
    chk("mid_rst_done", ack, 0);

    // ack phase with a stuck request
    do_reset();
    data_in = 32'h44A5_2211;
    req_sync = 4'b1000;
    out_ready = 1'b1;
    tick();
    chk("stuck_grant_src", out_src, 3);
    tick();
    chk("stuck_ack_on", ack, 4'b1000);
    req_sync = 4'b1001;
`ifdef HS_TIMEOUT_EN
    ack_cycles = 1;
    err_pulses = 0;
    to_done = 1'b0;
    for (int t = 0; t < 40 && !to_done; t++) begin
      tick();
      if (err) err_pulses++;
      if (ack == 4'b1000) ack_cycles++;
      else to_done = 1'b1;
    end
    chk("to_dropped", to_done, 1);
    chk("to_ack_cycles", ack_cycles, TO);
    chk("to_err_at_drop", err, 1);
    chk("to_ack_zero", ack, 0);
    tick();
    if (err) err_pulses++;
    chk("to_err_pulses", err_pulses, 1);
    chk("to_next_valid", out_valid, 1);
    chk("to_next_src", out_src, 0);
`else
    held = 1'b1;
    for (int t = 0; t < 20; t++) begin
      tick();
      if (ack !== 4'b1000 || err !== 1'b0) held = 1'b0;
    end
    chk("noto_ack_held", held, 1);
    req_sync = 4'b0001;
    tick();
    chk("noto_ack_drop", ack, 0);
    tick();
    chk("noto_next_valid", out_valid, 1);
    chk("noto_next_src", out_src, 0);
`endif

    // randomized traffic against the reference model
    do_reset();
    m_ptr = 0; m_word = 1'b0; m_ack = -1; m_src = 0; m_data = '0; words = 0;
    ag_req = '0;
    for (int i = 0; i < N; i++) begin
      ag_st[i] = 0;
      ag_wait[i] = $urandom_range(0, 4);
      ag_data[i] = '0;
    end
    data_in = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pr = req_sync;
      prdy = out_ready;
      tick();
      if (m_word) begin
        if (prdy) begin
          m_word = 1'b0;
          m_ack = m_src;
          words++;
        end
      end else if (m_ack >= 0) begin
        if (!pr[m_ack]) begin
          m_ptr = (m_ack + 1) % N;
          m_ack = -1;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (!found && pr[idx]) begin
            found = 1'b1;
            m_word = 1'b1;
            m_src = idx;
            m_data = ag_data[idx];
          end
        end
      end
      exp_ack = (m_ack >= 0) ? (4'b0001 << m_ack) : 4'b0000;
      chk("rand_valid", out_valid, m_word);
      if (m_word) begin
        chk("rand_src", out_src, m_src);
        chk("rand_data", out_data, m_data);
      end
      chk("rand_ack", ack, exp_ack);
      chk("rand_busy", busy, (m_word || m_ack >= 0));
      chk("rand_err", err, 0);

      for (int i = 0; i < N; i++) begin
        case (ag_st[i])
          0: if (ag_wait[i] == 0) begin
               ag_data[i] = 8'($urandom);
               ag_req[i] = 1'b1;
               ag_st[i] = 1;
             end else ag_wait[i]--;
          1: if (ack[i]) begin
               ag_wait[i] = $urandom_range(0, 3);
               ag_st[i] = 2;
             end
          2: if (ag_wait[i] == 0) begin
               ag_req[i] = 1'b0;
               ag_st[i] = 3;
             end else ag_wait[i]--;
          default: if (!ack[i]) begin
               ag_wait[i] = $urandom_range(0, 5);
               ag_st[i] = 0;
             end
        endcase
        data_in[i*DW +: DW] = ag_data[i];
      end
      req_sync = ag_req;
      out_ready = ($urandom_range(0, 3) != 0);
    end
    chk("rand_progress", (words >= 50), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
